result_drain: RTL
=================

Name: result_drain

Overview:
- Downstream neighbour of the systolic array stage.
- On a start pulse, snapshots the full AROW x BCOL accumulator matrix, optionally applies ReLU, and streams elements in row-major order over a valid/ready interface.
- Each element carries its write address for the activation/output BRAM.
- Frees the array to begin the next tile as soon as the snapshot is taken.

Parameters:
- N, 16, element width in bits, two's complement fixed point (same as array).
- AROW, 15, result rows.
- BCOL, 15, result columns.
- ADDR_WID, 8, output BRAM address width; AROW*BCOL must be <= 2**ADDR_WID.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass through.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: the array results are final this cycle.
- sys_array  in  AROW*BCOL*N  accumulator matrix, flattened; element (r,c) occupies bits [(r*BCOL+c)*N +: N].
- base_addr  in  ADDR_WID  BRAM address of element (0,0); sampled together with start.
- out_valid  out  1  out_data/out_addr are valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  N  post-ReLU element.
- out_addr  out  ADDR_WID  base + r*BCOL + c, modulo 2**ADDR_WID.
- out_last  out  1  high with the final element (AROW-1, BCOL-1).
- busy  out  1  high in DRAIN.
- done  out  1  one-cycle pulse after the last handshake.
- start_err  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (async, any state): state = IDLE; row/col counters = 0; snapshot register = 0; latched base = 0; all outputs 0.
- States: IDLE, DRAIN, DONE.
- IDLE: when start = 1 at an edge, on that same edge:
  - capture sys_array into the snapshot and base_addr into the latched base;
  - set row = col = 0;
  - go to DRAIN.
  - out_valid rises the next cycle, so first-data latency is 1 cycle after start.
- DRAIN:
  - out_valid = 1 (registered-state decode).
  - out_data = f(snapshot[row][col]), combinational from the snapshot. f(x) = 0 if RELU_EN and x[N-1] = 1, else x. f(most-negative) = 0.
  - out_addr = latched base + row*BCOL + col, truncated to ADDR_WID (wraps).
  - On a handshake:
    - col increments; at BCOL-1, col = 0 and row increments.
    - On the handshake with row = AROW-1 and col = BCOL-1 (out_last = 1), go to DONE.
  - Without a handshake, all outputs hold stable; no data change while valid && !ready.
- DONE: done = 1 for exactly one cycle, out_valid = 0, then go to IDLE.
  - A start in DONE is accepted exactly as in IDLE (capture, go to DRAIN), with no bubble beyond the DONE cycle.
- start while in DRAIN: ignored, snapshot unchanged, start_err pulses the following cycle.
- Throughput: 1 element/cycle with out_ready held high; a full drain takes AROW*BCOL cycles plus 1 DONE cycle.
- sys_array is sampled only on the start edge; later changes have no effect.
- Reset mid-drain: out_valid drops immediately (async), and no done pulse is issued.

Decomposition:
- Shared package (nn_pkg): drain_state_t enum {IDLE, DRAIN, DONE} and a function computing element bit offset (r*BCOL+c)*N. The package reuses the design-wide N / FIXED_POINT_POSITION constants.
- One natural sub-module: relu_unit (N, RELU_EN), purely combinational, element in -> element out.
- Counters and snapshot stay in result_drain.

Test Plan:
- AROW=2, BCOL=3, base=0x10, out_ready=1, matrix {1,-2,3; -4,5,6} (RELU_EN=1) -> six consecutive outputs:
  - data 1,0,3,0,5,6;
  - addr 0x10..0x15;
  - out_last on 6th;
  - done pulses the cycle after.
- Same with RELU_EN=0 -> data 1,-2,3,-4,5,6 (0xFFFE, 0xFFFC for N=16).
- out_ready toggled 1,0,0,1,... -> no element dropped or duplicated; data/addr stable during stalls; order preserved.
- base=0xFE, ADDR_WID=8 -> addr sequence 0xFE, 0xFF, 0x00, 0x01, 0x02, 0x03 (wrap).
- start asserted on 3rd element of a drain with a different matrix -> start_err pulse; the remaining outputs still come from the first matrix.
- rst asserted mid-drain (element 2) -> out_valid = 0 at once, busy = 0, no done. A fresh start afterward drains from element (0,0) with the new data.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: element format
// constants, the result-drain state encoding and flat-matrix indexing.
package nn_pkg;

    localparam int N                    = 16;
    localparam int FIXED_POINT_POSITION = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    // Bit offset of element (r,c) inside a row-major flattened matrix.
    function automatic int elem_offset(input int r, input int c, input int bcol, input int n);
        return (r * bcol + c) * n;
    endfunction

endpackage

// File: rtl/relu_unit.sv
// Combinational ReLU on one fixed-point element; a pure pass-through when
// RELU_EN is 0. The most negative value clamps to 0 like any other negative.
module relu_unit #(
    parameter int N       = 16,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    // Sign bit alone decides the clamp.
    assign dout = (RELU_EN && din[N-1]) ? '0 : din;

endmodule

// File: rtl/result_drain.sv
// Result drain: snapshots the accumulator matrix on start, then streams the
// (optionally ReLU'd) elements in row-major order with their BRAM addresses.
// The snapshot frees the array for the next tile immediately.
module result_drain
    import nn_pkg::*;
#(
    parameter int N        = nn_pkg::N,
    parameter int AROW     = 15,
    parameter int BCOL     = 15,
    parameter int ADDR_WID = 8,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AROW*BCOL*N-1:0]   sys_array,
    input  logic [ADDR_WID-1:0]      base_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic [ADDR_WID-1:0]      out_addr,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     start_err
);

    localparam int ELEMS = AROW * BCOL;
    localparam int RW    = (AROW > 1) ? $clog2(AROW) : 1;
    localparam int CW    = (BCOL > 1) ? $clog2(BCOL) : 1;
    localparam int IW    = (ELEMS * N > 1) ? $clog2(ELEMS * N) : 1;

    drain_state_t           state_q;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic [ELEMS*N-1:0]     snap_q;
    logic [ADDR_WID-1:0]    base_q;
    logic                   start_err_q;

    logic                   at_last;
    logic [N-1:0]           elem_raw;

    assign at_last = (row_q == RW'(AROW - 1)) && (col_q == CW'(BCOL - 1));

    // Element currently presented, straight out of the snapshot.
    assign elem_raw = snap_q[IW'(elem_offset(int'(row_q), int'(col_q), BCOL, N)) +: N];

    relu_unit #(
        .N       (N),
        .RELU_EN (RELU_EN)
    ) u_relu (
        .din  (elem_raw),
        .dout (out_data)
    );

    // Address wraps modulo 2**ADDR_WID by truncation.
    assign out_addr  = base_q + ADDR_WID'(int'(row_q) * BCOL + int'(col_q));
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && at_last;
    assign done      = (state_q == DONE);
    assign start_err = start_err_q;

    // Drain FSM: capture on start (IDLE or DONE), walk row/col on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            snap_q      <= '0;
            base_q      <= '0;
            start_err_q <= 1'b0;
        end else begin
            start_err_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        snap_q  <= sys_array;
                        base_q  <= base_addr;
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    // A start here is dropped; the snapshot must not move mid-stream.
                    if (start) start_err_q <= 1'b1;
                    if (out_ready) begin
                        if (at_last) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= DONE;
                        end else if (col_q == CW'(BCOL - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
